uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_resp_buf.sv | 51 +++++
 rtl/uart_cmd_parser.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WAIT_CR = 4'd5,
    S_SKIP    = 4'd6,
    S_EXEC    = 4'd7,
    S_RD_WAIT = 4'd8,
    S_RESP    = 4'd9
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters A-F/a-f have bit 6 set and a low nibble of 1..6, so add 9.
  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    return b[6] ? (b[3:0] + 4'd9) : b[3:0];
  endfunction

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_resp_buf.sv
// Four-byte response buffer: loaded in one cycle by the parser, then
// serialized into the TX FIFO one byte per accepted push.
module uart_resp_buf (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [3:0][7:0] load_bytes,
  input  logic [2:0]      load_cnt,
  input  logic            en,
  input  logic            tx_full,
  output logic            tx_push,
  output logic [7:0]      tx_data,
  output logic            done
);

  logic [3:0][7:0] bytes_q, bytes_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;

  assign tx_push = en & ~tx_full;
  assign tx_data = bytes_q[idx_q];
  assign done    = tx_push & ({1'b0, idx_q} == (cnt_q - 3'd1));

  // Next-state: a load restarts the byte index, each push advances it.
  always_comb begin
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (load) begin
      bytes_d = load_bytes;
      cnt_d   = load_cnt;
      idx_d   = 2'd0;
    end else if (tx_push) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Buffer registers; reset drops any unsent bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q <= '0;
      cnt_q   <= 3'd0;
      idx_q   <= 2'd0;
    end else begin
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII hex register-access command parser between the UART RX and TX FIFOs.
// Accepts "W AA DD CR" and "R AA CR", drives an 8-bit register bus and
// answers with K/E or the read value as two uppercase hex digits.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] ACK_CHAR = 8'h4B,
  parameter logic [7:0] ERR_CHAR = 8'h45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [3:0]      addr_hi_q, addr_hi_d;
  logic [3:0]      data_hi_q, data_hi_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic            err_ld;
  logic            ld;
  logic [3:0][7:0] ld_bytes;
  logic [2:0]      ld_cnt;
  logic            resp_done;
  logic            in_rx_state;
  logic            rx_hex;
  logic [3:0]      rx_nib;

  assign in_rx_state = (state_q == S_IDLE)    || (state_q == S_ADDR_HI) ||
                       (state_q == S_ADDR_LO) || (state_q == S_DATA_HI) ||
                       (state_q == S_DATA_LO) || (state_q == S_WAIT_CR) ||
                       (state_q == S_SKIP);
  // Strobes are masked during reset so a reset cycle never consumes or emits.
  assign rx_pop    = in_rx_state & ~rx_empty & ~rst;
  assign reg_we    = (state_q == S_EXEC) & wr_q & ~rst;
  assign reg_re    = (state_q == S_EXEC) & ~wr_q & ~rst;
  assign busy      = (state_q != S_IDLE);
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign rx_hex    = is_hex(rx_data);
  assign rx_nib    = hex2nib(rx_data);

  // Command FSM: one byte per pop; address/data words only change once
  // their low nibble arrives, so the bus never sees a half-updated value.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_hi_d   = addr_hi_q;
    data_hi_d   = data_hi_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_ld      = 1'b0;
    ld          = 1'b0;
    ld_bytes    = '0;
    ld_cnt      = 3'd0;
    case (state_q)
      S_IDLE: if (rx_pop) begin
        // OR-ing in 0x20 folds the command letter to lowercase.
        if ((rx_data | 8'h20) == 8'h77) begin
          wr_d    = 1'b1;
          state_d = S_ADDR_HI;
        end else if ((rx_data | 8'h20) == 8'h72) begin
          wr_d    = 1'b0;
          state_d = S_ADDR_HI;
        end else if (!((rx_data == CR) || (rx_data == LF) || (rx_data == SP))) begin
          state_d = S_SKIP;
        end
      end
      S_ADDR_HI: if (rx_pop) begin
        if (rx_hex) begin
          addr_hi_d = rx_nib;
          state_d   = S_ADDR_LO;
        end else if (rx_data == CR) err_ld = 1'b1;
        else state_d = S_SKIP;
      end
      S_ADDR_LO: if (rx_pop) begin
        if (rx_hex) begin
          reg_addr_d = {addr_hi_q, rx_nib};
          state_d    = wr_q ? S_DATA_HI : S_WAIT_CR;
        end else if (rx_data == CR) err_ld = 1'b1;
        else state_d = S_SKIP;
      end
      S_DATA_HI: if (rx_pop) begin
        if (rx_hex) begin
          data_hi_d = rx_nib;
          state_d   = S_DATA_LO;
        end else if (rx_data == CR) err_ld = 1'b1;
        else state_d = S_SKIP;
      end
      S_DATA_LO: if (rx_pop) begin
        if (rx_hex) begin
          reg_wdata_d = {data_hi_q, rx_nib};
          state_d     = S_WAIT_CR;
        end else if (rx_data == CR) err_ld = 1'b1;
        else state_d = S_SKIP;
      end
      S_WAIT_CR: if (rx_pop) begin
        state_d = (rx_data == CR) ? S_EXEC : S_SKIP;
      end
      S_SKIP: if (rx_pop && (rx_data == CR)) err_ld = 1'b1;
      S_EXEC: begin
        if (wr_q) begin
          ld       = 1'b1;
          ld_bytes = {8'h00, LF, CR, ACK_CHAR};
          ld_cnt   = 3'd3;
          state_d  = S_RESP;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        ld       = 1'b1;
        ld_bytes = {LF, CR, nib2hex(reg_rdata[3:0]), nib2hex(reg_rdata[7:4])};
        ld_cnt   = 3'd4;
        state_d  = S_RESP;
      end
      S_RESP: if (resp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (err_ld) begin
      ld       = 1'b1;
      ld_bytes = {8'h00, LF, CR, ERR_CHAR};
      ld_cnt   = 3'd3;
      state_d  = S_RESP;
    end
  end

  // Parser registers; reset abandons any partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_hi_q   <= 4'h0;
      data_hi_q   <= 4'h0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_hi_q   <= addr_hi_d;
      data_hi_q   <= data_hi_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  uart_resp_buf u_resp (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .load_bytes (ld_bytes),
    .load_cnt   (ld_cnt),
    .en         ((state_q == S_RESP) & ~rst),
    .tx_full    (tx_full),
    .tx_push    (tx_push),
    .tx_data    (tx_data),
    .done       (resp_done)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: RX/TX FIFO and register-bus models, a
// line-oriented reference parser, directed cases and randomized command mixes.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  uart_cmd_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_pop    (rx_pop),
    .tx_full   (tx_full),
    .tx_push   (tx_push),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;

  logic [7:0]  rx_q[$];
  logic [7:0]  stim[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] op_obs[$];
  logic [31:0] exp_ops[$];
  int          push_cyc[$];
  logic [7:0]  busmem[256];
  logic [7:0]  mem_model[256];
  int          cyc = 0;
  int          last_cr_cyc = 0;
  int          gap_len = 0;
  int          gap_cnt = 0;
  int          rx_empty_pct = 0;
  int          tx_full_pct = 0;
  bit          stall = 1'b0;
  bit          rd_pending = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  // Reference: split the byte stream into CR-terminated lines and judge each whole line.
  task automatic model_line(input logic [7:0] l[$]);
    bit ok;
    bit wr;
    logic [7:0] a, d;
    if (l.size() == 0) return;
    ok = 1'b1;
    wr = 1'b0;
    if ((l[0] == "W") || (l[0] == "w")) begin wr = 1'b1; ok = (l.size() == 5); end
    else if ((l[0] == "R") || (l[0] == "r")) ok = (l.size() == 3);
    else ok = 1'b0;
    for (int i = 1; i < l.size(); i++) if (hexv(l[i]) < 0) ok = 1'b0;
    if (!ok) begin
      exp_tx.push_back(8'h45); exp_tx.push_back(C_CR); exp_tx.push_back(C_LF);
      return;
    end
    a = 8'(hexv(l[1]) * 16 + hexv(l[2]));
    if (wr) begin
      d = 8'(hexv(l[3]) * 16 + hexv(l[4]));
      mem_model[a] = d;
      exp_ops.push_back({15'd0, 1'b1, a, d});
      exp_tx.push_back(8'h4B); exp_tx.push_back(C_CR); exp_tx.push_back(C_LF);
    end else begin
      d = mem_model[a];
      exp_ops.push_back({15'd0, 1'b0, a, 8'h00});
      exp_tx.push_back(hexch(d[7:4])); exp_tx.push_back(hexch(d[3:0]));
      exp_tx.push_back(C_CR); exp_tx.push_back(C_LF);
    end
  endtask

  task automatic model_run();
    logic [7:0] line[$];
    line = {};
    foreach (stim[i]) begin
      if (stim[i] == C_CR) begin
        model_line(line);
        line = {};
      end else if (!(line.size() == 0 && (stim[i] == C_LF || stim[i] == 8'h20))) begin
        line.push_back(stim[i]);
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, then record what the
  // DUT will do at the coming rising edge.
  task automatic tick();
    @(negedge clk);
    reg_rdata  = rd_pending ? busmem[rd_addr] : 8'($urandom);
    rd_pending = 1'b0;
    tx_full    = stall || ($urandom_range(99) < tx_full_pct);
    if (gap_cnt > 0) begin
      gap_cnt--;
      rx_empty = 1'b1;
    end else begin
      rx_empty = (rx_q.size() == 0) || ($urandom_range(99) < rx_empty_pct);
    end
    rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'($urandom);
    #1;
    if (rx_pop) begin
      check("pop while empty", {31'd0, rx_empty}, 32'd0);
      if (!rx_empty) begin
        if (rx_q[0] == C_CR) last_cr_cyc = cyc;
        void'(rx_q.pop_front());
        if (gap_len > 0) gap_cnt = gap_len;
      end
    end
    if (tx_push) begin
      check("push while full", {31'd0, tx_full}, 32'd0);
      tx_obs.push_back(tx_data);
      push_cyc.push_back(cyc);
    end
    if (reg_we) begin
      op_obs.push_back({15'd0, 1'b1, reg_addr, reg_wdata});
      busmem[reg_addr] = reg_wdata;
      check("we latency", cyc - last_cr_cyc, 32'd1);
    end
    if (reg_re) begin
      op_obs.push_back({15'd0, 1'b0, reg_addr, 8'h00});
      rd_pending = 1'b1;
      rd_addr    = reg_addr;
      check("re latency", cyc - last_cr_cyc, 32'd1);
    end
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_q.push_back(b);
    stim.push_back(b);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic begin_scn();
    stim = {}; tx_obs = {}; exp_tx = {}; op_obs = {}; exp_ops = {}; push_cyc = {};
  endtask

  task automatic finish_scn(input string name, input int budget);
    int t;
    model_run();
    t = 0;
    while ((rx_q.size() != 0 || busy) && t < budget) begin
      tick();
      t++;
    end
    check({name, " idle"}, {31'd0, (rx_q.size() == 0) && !busy}, 32'd1);
    repeat (3) tick();
    check({name, " tx count"}, tx_obs.size(), exp_tx.size());
    for (int i = 0; i < tx_obs.size() && i < exp_tx.size(); i++)
      check($sformatf("%s tx[%0d]", name, i), {24'd0, tx_obs[i]}, {24'd0, exp_tx[i]});
    check({name, " op count"}, op_obs.size(), exp_ops.size());
    for (int i = 0; i < op_obs.size() && i < exp_ops.size(); i++)
      check($sformatf("%s op[%0d]", name, i), op_obs[i], exp_ops[i]);
  endtask

  task automatic wait_first_push(input int budget);
    int t;
    t = 0;
    while (tx_obs.size() < 1 && t < budget) begin
      tick();
      t++;
    end
    check("first push seen", {31'd0, tx_obs.size() >= 1}, 32'd1);
  endtask

  // Random command: valid or corrupted, mixed case.
  task automatic gen_cmd();
    logic [7:0] c[$];
    logic [3:0] n;
    logic [7:0] h;
    int nd, k;
    bit wr;
    c  = {};
    wr = 1'($urandom_range(1));
    c.push_back(wr ? 8'h57 : 8'h52);
    if ($urandom_range(1) == 1) c[0] = c[0] | 8'h20;
    nd = wr ? 4 : 2;
    for (int i = 0; i < nd; i++) begin
      n = 4'($urandom);
      h = hexch(n);
      if (n > 4'd9 && $urandom_range(1) == 1) h = h | 8'h20;
      c.push_back(h);
    end
    case ($urandom_range(9))
      0: c[$urandom_range(nd, 1)] = 8'h47;
      1: begin
        k = $urandom_range(nd - 1, 0);
        while (c.size() > k + 1) void'(c.pop_back());
      end
      2: c[0] = 8'h51;
      3: c.push_back(8'h37);
      4: begin c.push_front(8'h20); c.push_front(C_LF); end
      5: c[$urandom_range(nd, 1)] = 8'h20;
      default: ;
    endcase
    c.push_back(C_CR);
    foreach (c[i]) send_byte(c[i]);
  endtask

  initial begin
    int bad;
    logic [7:0] d0;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_empty  = 1'b1;
    tx_full   = 1'b0;
    reg_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      busmem[i]    = 8'($urandom);
      mem_model[i] = busmem[i];
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset tx_push", {31'd0, tx_push}, 32'd0);
    check("reset reg_we", {31'd0, reg_we}, 32'd0);
    check("reset reg_re", {31'd0, reg_re}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);
    check("reset reg_addr", {24'd0, reg_addr}, 32'd0);
    check("reset reg_wdata", {24'd0, reg_wdata}, 32'd0);

    // Plain write.
    begin_scn();
    send("W1A5C\015");
    finish_scn("write", 200);
    if (push_cyc.size() >= 3) begin
      check("write first push latency", push_cyc[0] - last_cr_cyc, 32'd2);
      check("write last push latency", push_cyc[2] - last_cr_cyc, 32'd4);
    end

    // Lowercase read.
    busmem[8'h1A]    = 8'hB7;
    mem_model[8'h1A] = 8'hB7;
    begin_scn();
    send("r1a\015");
    finish_scn("read", 200);
    if (push_cyc.size() >= 4) begin
      check("read first push latency", push_cyc[0] - last_cr_cyc, 32'd3);
      check("read last push latency", push_cyc[3] - last_cr_cyc, 32'd6);
    end

    // Bad hex, early CR, then recovery.
    begin_scn();
    send("WZZ\015R1\015R00\015");
    finish_scn("errors", 300);

    // TX backpressure for 10 cycles mid-response; a read waits in the RX FIFO.
    begin_scn();
    send("W3344\015R00\015");
    wait_first_push(100);
    stall = 1'b1;
    bad   = 0;
    d0    = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) d0 = tx_data;
      if (tx_push || rx_pop || (tx_data !== d0)) bad++;
    end
    stall = 1'b0;
    check("stall held byte", {24'd0, d0}, {24'd0, C_CR});
    check("stall activity", bad, 32'd0);
    finish_scn("stall", 300);

    // Slow RX FIFO plus leading CR/LF.
    begin_scn();
    gap_len = 5;
    send("W0011\015\015\012R00\015");
    finish_scn("gaps", 500);
    gap_len = 0;
    gap_cnt = 0;

    // Reset one cycle after the first response byte leaves.
    begin_scn();
    send("R05\015");
    wait_first_push(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst tx_push", {31'd0, tx_push}, 32'd0);
    check("midrst tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst reg_addr", {24'd0, reg_addr}, 32'd0);
    check("midrst reg_wdata", {24'd0, reg_wdata}, 32'd0);
    check("midrst strobes", {30'd0, reg_we, reg_re}, 32'd0);
    repeat (10) tick();
    check("midrst push count", tx_obs.size(), 32'd1);
    check("midrst op count", op_obs.size(), 32'd1);
    begin_scn();
    send("R00\015");
    finish_scn("after reset", 200);

    // Randomized command mixes with RX gaps and TX backpressure.
    rx_empty_pct = 30;
    tx_full_pct  = 30;
    for (int r = 0; r < 4; r++) begin
      begin_scn();
      repeat (8) gen_cmd();
      finish_scn($sformatf("random%0d", r), 4000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
